ddr_reader: RTL

- Read-side counterpart of the DDR write path: walks a tensor stored in DDR in the same layout the writer produces.
- Channel-interleaved layout; xy stride = c*(B_PIXEL/8) bytes; channel-group stride = N_DSP_GROUP*(B_PIXEL/8) bytes.
- Issues read addresses on an AXI-stream request channel and receives read data on an AXI-stream response channel.
- Forwards data, with a last marker, to a downstream DSP consumer under ready/valid flow control.
- Bounds outstanding requests with a credit counter.

---
 rtl/ddr_reader_if.sv | 35 +++
 rtl/ddr_reader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ddr_reader_if.sv
// Stream bundle for ddr_reader: read-request channel, read-data return channel,
// and the forwarded data stream toward the DSP consumer.
interface ddr_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  rd_ready;

  modport master (
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output rd_data, rd_valid, rd_last,
    input  rd_ready
  );

  modport slave (
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  rd_data, rd_valid, rd_last,
    output rd_ready
  );
endinterface

// File: rtl/ddr_reader.sv
// Walks a channel-interleaved tensor in DDR (xy inner, channel group outer), issues
// read addresses under a credit limit and forwards returned beats with a last marker.
module ddr_reader #(
  parameter int B_PIXEL         = 16,
  parameter int N_DSP_GROUP     = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [31:0]  base_addr,
  input  logic [31:0]  shape,
  output logic         busy,
  output logic         done,
  ddr_reader_if.master bus
);
  localparam int BPB = B_PIXEL / 8;
  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]         MAX_OUT    = OW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] GRP_STRIDE = ADDR_WIDTH'(N_DSP_GROUP * BPB);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]            state;
  logic [31:0]           total;
  logic [19:0]           wh;
  logic [ADDR_WIDTH-1:0] xy_stride;
  logic [19:0]           xy_cnt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] grp_base;
  logic [31:0]           load_cnt;
  logic [31:0]           ret_cnt;
  logic [OW-1:0]         outstanding;

  // shape decode and request count, evaluated on the start cycle
  logic [9:0]  w_in, h_in;
  logic [11:0] c_in;
  logic [19:0] wh_in;
  logic [11:0] ngrp_in;
  logic [31:0] total_in;
  logic        shape_zero;

  assign w_in       = shape[9:0];
  assign h_in       = shape[19:10];
  assign c_in       = shape[31:20];
  assign wh_in      = 20'(w_in) * 20'(h_in);
  assign ngrp_in    = 12'((13'(c_in) + 13'(N_DSP_GROUP - 1)) / 13'(N_DSP_GROUP));
  assign total_in   = 32'(wh_in) * 32'(ngrp_in);
  assign shape_zero = (w_in == '0) || (h_in == '0) || (c_in == '0);

  logic          active, req_hs, resp_hs, more_req, can_load, last_req, drain_ok;
  logic [OW-1:0] out_next;

  assign active           = (state == S_RUN) || (state == S_DRAIN);
  assign req_hs           = bus.m_axis_tvalid && bus.m_axis_tready;
  assign bus.s_axis_tready = rstn && (!bus.rd_valid || bus.rd_ready);
  // beats arriving with no request in flight (or outside a walk) are accepted and dropped
  assign resp_hs  = bus.s_axis_tvalid && bus.s_axis_tready && active && (outstanding != '0);
  assign out_next = outstanding + OW'(req_hs) - OW'(resp_hs);
  assign more_req = (load_cnt != total);
  assign can_load = (state == S_RUN) && more_req &&
                    (!bus.m_axis_tvalid || bus.m_axis_tready) && (out_next < MAX_OUT);
  assign last_req = req_hs && !more_req;
  // exit as the final beat leaves the output register, so done follows that handshake directly
  assign drain_ok = (ret_cnt == total) && (!bus.rd_valid || bus.rd_ready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      total     <= '0;
      wh        <= '0;
      xy_stride <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy      <= 1'b1;
          total     <= total_in;
          wh        <= wh_in;
          xy_stride <= ADDR_WIDTH'(c_in) * ADDR_WIDTH'(BPB);
          state     <= shape_zero ? S_FIN : S_RUN;
        end
        S_RUN:   if (last_req) state <= S_DRAIN;
        S_DRAIN: if (drain_ok) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // request register: the next address loads as soon as the slot frees and credit allows
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      cur_addr          <= '0;
      grp_base          <= '0;
      xy_cnt            <= '0;
      load_cnt          <= '0;
    end else if (state == S_IDLE) begin
      bus.m_axis_tvalid <= 1'b0;
      if (start) begin
        cur_addr <= ADDR_WIDTH'(base_addr);
        grp_base <= ADDR_WIDTH'(base_addr);
        xy_cnt   <= '0;
        load_cnt <= '0;
      end
    end else if (can_load) begin
      bus.m_axis_tvalid <= 1'b1;
      bus.m_axis_tdata  <= cur_addr;
      load_cnt          <= load_cnt + 32'd1;
      if (xy_cnt == wh - 20'd1) begin
        xy_cnt   <= '0;
        grp_base <= grp_base + GRP_STRIDE;
        cur_addr <= grp_base + GRP_STRIDE;
      end else begin
        xy_cnt   <= xy_cnt + 20'd1;
        cur_addr <= cur_addr + xy_stride;
      end
    end else if (req_hs) begin
      bus.m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outstanding <= '0;
      ret_cnt     <= '0;
    end else if (state == S_IDLE) begin
      outstanding <= '0;
      ret_cnt     <= '0;
    end else begin
      outstanding <= out_next;
      if (resp_hs) ret_cnt <= ret_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_last  <= 1'b0;
    end else if (resp_hs) begin
      bus.rd_data  <= bus.s_axis_tdata;
      bus.rd_valid <= 1'b1;
      bus.rd_last  <= (ret_cnt == total - 32'd1);
    end else if (bus.rd_ready) begin
      bus.rd_valid <= 1'b0;
      bus.rd_last  <= 1'b0;
    end
  end
endmodule
